uart_tx_port: RTL and testbench

- Device-side end of the memory-mapped UART_TX register (IO slot 2).
- Sits beside the other IO slots in the memory block: takes the CPU store strobe and data, and returns a status word on the read path.
- Queues written bytes in a small FIFO and serialises them onto the tx pin as 8N1 frames, LSB first.
- Gives the CPU a pollable status word in place of a plain storage register.

---
 rtl/uart_tx_port_if.sv | 10 +
 rtl/uart_tx_port.sv | 119 +++++++++++
 tb/tb_uart_tx_port.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_port_if.sv
// CPU-side bus of the UART_TX IO slot: store strobe/data in, status word and serial line out.
interface uart_tx_port_if;
  logic        load;
  logic [15:0] in;
  logic [15:0] out;
  logic        tx;

  modport master (output load, in, input out, tx);
  modport slave  (input load, in, output out, tx);
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: bytes queue in a small FIFO and leave as 8N1 frames, LSB first.
// The read path returns {overflow, busy, full} instead of stored data.
module uart_tx_port #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_port_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          ovf_q, ovf_d;
  logic          tx_q, tx_d;

  logic full, wr_data, push, pop, baud_done;
  logic unused_in;

  assign unused_in = ^bus.in[14:8];
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign wr_data   = bus.load && !bus.in[15];
  assign push      = wr_data && !full;
  assign baud_done = (baud_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
      baud_q  <= '0;
      ovf_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      baud_q  <= baud_d;
      ovf_q   <= ovf_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.in[7:0];
  end

  // Next state; pop is the only FSM decision that reaches the FIFO
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE:  if (cnt_q != '0) begin pop = 1'b1; state_d = START; end
      START: if (baud_done) state_d = DATA;
      DATA:  if (baud_done && idx_q == 3'd7) state_d = STOP;
      STOP:  if (baud_done) begin
               if (cnt_q != '0) begin pop = 1'b1; state_d = START; end
               else state_d = IDLE;
             end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath; tx is registered from the next state so it never sees load/in
  always_comb begin
    baud_d  = baud_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (pop || (state_q != IDLE && baud_done)) baud_d = BAUD_RELOAD;
    else if (state_q != IDLE)                  baud_d = baud_q - BW'(1);

    if (pop) shift_d = mem_q[rptr_q];
    else if (state_q == DATA && baud_done) shift_d = shift_q >> 1;

    if (state_q == START) idx_d = 3'd0;
    else if (state_q == DATA && baud_done) idx_d = idx_q + 3'd1;

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    if (bus.load && bus.in[15])  ovf_d = 1'b0;
    else if (wr_data && full)    ovf_d = 1'b1;

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign bus.tx  = tx_q;
  assign bus.out = {13'b0, ovf_q, (state_q != IDLE) || (cnt_q != '0), full};
endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: a frame-level timing model predicts tx and the status word every cycle.
module tb_uart_tx_port;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic clk, reset;
  int   cyc;
  int   checks, errors;

  uart_tx_port_if bus ();
  uart_tx_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: each accepted byte is a frame with accept edge a, start edge s and end edge e.
  typedef struct {int a; int s; int e; logic [7:0] d;} frame_t;
  frame_t fq[$];
  int     last_end;
  logic   m_ovf;

  function automatic int m_count(input int p);
    int n = 0;
    foreach (fq[k]) if (fq[k].a <= p && fq[k].s > p) n++;
    return n;
  endfunction

  function automatic logic m_tx(input int p);
    foreach (fq[k]) if (fq[k].s <= p && p < fq[k].e) begin
      int b = (p - fq[k].s) / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return fq[k].d[b-1];
      return 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_out(input int p);
    logic busy;
    int   n = m_count(p);
    busy = (n != 0);
    foreach (fq[k]) if (fq[k].s <= p && p < fq[k].e) busy = 1'b1;
    return {13'b0, m_ovf, busy, n == DEPTH};
  endfunction

  function automatic void m_write(input int a, input logic [15:0] d);
    int s;
    if (d[15]) m_ovf = 1'b0;
    else if (m_count(a - 1) == DEPTH) m_ovf = 1'b1;
    else begin
      s = (a + 1 > last_end) ? a + 1 : last_end;
      fq.push_back('{a: a, s: s, e: s + FRAME, d: d[7:0]});
      last_end = s + FRAME;
    end
  endfunction

  function automatic void m_reset(input int r);
    m_ovf    = 1'b0;
    last_end = 0;
    for (int k = fq.size() - 1; k >= 0; k--) begin
      if (fq[k].s >= r) fq.delete(k);
      else if (fq[k].e > r) fq[k].e = r;
    end
  endfunction

  // Drive for the coming edge and record the write in the model.
  task automatic drive(input logic ld, input logic [15:0] d);
    bus.load = ld;
    bus.in   = d;
    if (ld) m_write(cyc + 1, d);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b0, 16'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    m_reset(cyc);
    checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", bus.tx); end
    checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", bus.out); end
  endtask

  task automatic test_single;
    for (int i = 0; i <= 50; i++) begin
      @(negedge clk);
      checks++; if (bus.tx !== m_tx(cyc)) begin errors++; $display("FAIL single_tx i=%0d got=%b exp=%b", i, bus.tx, m_tx(cyc)); end
      checks++; if (bus.out !== m_out(cyc)) begin errors++; $display("FAIL single_out i=%0d got=%h exp=%h", i, bus.out, m_out(cyc)); end
      if (i == 1) begin
        checks++; if (bus.tx !== 1'b1 || bus.out !== 16'h0002) begin errors++; $display("FAIL single_queued tx=%b out=%h exp tx=1 out=0002", bus.tx, bus.out); end
      end
      if (i == 2) begin checks++; if (bus.tx !== 1'b0) begin errors++; $display("FAIL single_start got=%b exp=0", bus.tx); end end
      if (i == 6) begin checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL single_bit0 got=%b exp=1", bus.tx); end end
      if (i == 10) begin checks++; if (bus.tx !== 1'b0) begin errors++; $display("FAIL single_bit1 got=%b exp=0", bus.tx); end end
      if (i == 41) begin checks++; if (bus.out !== 16'h0002) begin errors++; $display("FAIL single_stop_busy got=%h exp=0002", bus.out); end end
      if (i == 42) begin checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL single_done got=%h exp=0000", bus.out); end end
      drive(i == 0, 16'h0055);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i <= 90; i++) begin
      @(negedge clk);
      checks++; if (bus.tx !== m_tx(cyc)) begin errors++; $display("FAIL b2b_tx i=%0d got=%b exp=%b", i, bus.tx, m_tx(cyc)); end
      checks++; if (bus.out !== m_out(cyc)) begin errors++; $display("FAIL b2b_out i=%0d got=%h exp=%h", i, bus.out, m_out(cyc)); end
      if (i == 41) begin checks++; if (bus.tx !== 1'b1) begin errors++; $display("FAIL b2b_stop got=%b exp=1", bus.tx); end end
      if (i == 42) begin checks++; if (bus.tx !== 1'b0) begin errors++; $display("FAIL b2b_nogap got=%b exp=0", bus.tx); end end
      if (i == 82) begin checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL b2b_done got=%h exp=0000", bus.out); end end
      drive(i <= 1, (i == 0) ? 16'h0041 : 16'h0042);
    end
  endtask

  task automatic test_fill_overflow;
    for (int i = 0; i <= 210; i++) begin
      @(negedge clk);
      checks++; if (bus.tx !== m_tx(cyc)) begin errors++; $display("FAIL fill_tx i=%0d got=%b exp=%b", i, bus.tx, m_tx(cyc)); end
      checks++; if (bus.out !== m_out(cyc)) begin errors++; $display("FAIL fill_out i=%0d got=%h exp=%h", i, bus.out, m_out(cyc)); end
      if (i == 5) begin checks++; if (bus.out !== 16'h0003) begin errors++; $display("FAIL fill_full got=%h exp=0003", bus.out); end end
      if (i == 6) begin checks++; if (bus.out !== 16'h0007) begin errors++; $display("FAIL fill_ovf got=%h exp=0007", bus.out); end end
      if (i == 7) begin checks++; if (bus.out !== 16'h0003) begin errors++; $display("FAIL fill_clr got=%h exp=0003", bus.out); end end
      if (i == 210) begin checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL fill_done got=%h exp=0000", bus.out); end end
      if (i <= 5)      drive(1'b1, {8'h00, 8'h10 + 8'(i)});
      else if (i == 6) drive(1'b1, 16'h8000);
      else             drive(1'b0, 16'h0000);
    end
  endtask

  task automatic test_push_pop;
    logic [15:0] dat [4] = '{16'h00C3, 16'h0018, 16'h00E7, 16'h0099};
    for (int i = 0; i <= 170; i++) begin
      @(negedge clk);
      checks++; if (bus.tx !== m_tx(cyc)) begin errors++; $display("FAIL pushpop_tx i=%0d got=%b exp=%b", i, bus.tx, m_tx(cyc)); end
      checks++; if (bus.out !== m_out(cyc)) begin errors++; $display("FAIL pushpop_out i=%0d got=%h exp=%h", i, bus.out, m_out(cyc)); end
      if (i == 41 || i == 42) begin
        checks++; if (bus.out !== 16'h0002) begin errors++; $display("FAIL pushpop_cnt i=%0d got=%h exp=0002", i, bus.out); end
      end
      if (i == 170) begin checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL pushpop_done got=%h exp=0000", bus.out); end end
      if (i <= 2)       drive(1'b1, dat[i]);
      else if (i == 41) drive(1'b1, dat[3]);
      else              drive(1'b0, 16'h0000);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i <= 135; i++) begin
      @(negedge clk);
      reset = 1'b0;
      checks++; if (bus.tx !== m_tx(cyc)) begin errors++; $display("FAIL rstmid_tx i=%0d got=%b exp=%b", i, bus.tx, m_tx(cyc)); end
      checks++; if (bus.out !== m_out(cyc)) begin errors++; $display("FAIL rstmid_out i=%0d got=%h exp=%h", i, bus.out, m_out(cyc)); end
      if (i == 19) begin
        checks++; if (bus.tx !== 1'b1 || bus.out !== 16'h0000) begin errors++; $display("FAIL rstmid_abort tx=%b out=%h exp tx=1 out=0000", bus.tx, bus.out); end
      end
      if (i == 135) begin checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL rstmid_done got=%h exp=0000", bus.out); end end
      if (i <= 2)       drive(1'b1, {8'h00, 8'hA5 ^ 8'(i)});
      else if (i == 18) begin drive(1'b0, 16'h0000); reset = 1'b1; m_reset(cyc + 1); end
      else if (i == 80) drive(1'b1, 16'h003C);
      else              drive(1'b0, 16'h0000);
    end
  endtask

  task automatic test_random;
    int r;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      checks++; if (bus.tx !== m_tx(cyc)) begin errors++; $display("FAIL rand_tx i=%0d got=%b exp=%b", i, bus.tx, m_tx(cyc)); end
      checks++; if (bus.out !== m_out(cyc)) begin errors++; $display("FAIL rand_out i=%0d got=%h exp=%h", i, bus.out, m_out(cyc)); end
      r = (i < 3000) ? int'($urandom_range(0, 63)) : 63;
      if (r < 8)       drive(1'b1, {1'b0, 7'($urandom), 8'($urandom)});
      else if (r == 8) drive(1'b1, {1'b1, 15'($urandom)});
      else             drive(1'b0, 16'($urandom));
    end
    checks++; if (bus.out !== 16'h0000) begin errors++; $display("FAIL rand_done got=%h exp=0000", bus.out); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    last_end = 0;
    m_ovf    = 1'b0;
    reset    = 1'b1;
    bus.load = 1'b0;
    bus.in   = 16'h0;
    test_reset;
    test_single;
    test_back_to_back;
    test_fill_overflow;
    test_push_pop;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
